// File: rtl/fpu_sp_cmd_seq.sv
// Command sequencer in front of the single-precision FPU: buffers tagged requests,
// issues them one at a time and returns tagged results. Optional watchdog: FPU_SEQ_TIMEOUT_EN.
module fpu_sp_cmd_seq #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned TAG_W    = 4,
    parameter logic [3:0]  IDLE_CMD = 4'hF,
    parameter int unsigned TMO_CYC  = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [3:0]               req_cmd,
    input  logic [31:0]              req_din1,
    input  logic [31:0]              req_din2,
    input  logic [TAG_W-1:0]         req_tag,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [31:0]              resp_result,
    output logic [TAG_W-1:0]         resp_tag,
    output logic                     resp_err,
    output logic [3:0]               fpu_cmd,
    output logic [31:0]              fpu_din1,
    output logic [31:0]              fpu_din2,
    output logic                     fpu_dval,
    input  logic [31:0]              fpu_result,
    input  logic                     fpu_rdy,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned ENT_W = 4 + 32 + 32 + TAG_W;

    localparam logic [3:0] CMD_FPU_SP_ADD = 4'h0;
    localparam logic [3:0] CMD_FPU_SP_MUL = 4'h1;
    localparam logic [3:0] CMD_FPU_SP_DIV = 4'h2;
    localparam logic [3:0] CMD_FPU_SP_F2I = 4'h3;
    localparam logic [3:0] CMD_FPU_SP_I2F = 4'h4;

    // Elaboration-time parameter sanity checks
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TMO_CYC == 0) begin : g_bad_param
        $error("fpu_sp_cmd_seq: DEPTH must be a power of 2 >= 2 and TMO_CYC nonzero");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

    state_t             state_q, state_d;
    logic [ENT_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]   level_d;
    logic               push, pop;
    logic [ENT_W-1:0]   head;
    logic [3:0]         head_cmd;
    logic [31:0]        head_din1, head_din2;
    logic [TAG_W-1:0]   head_tag;
    logic               head_ok;

    logic               req_ready_d, resp_valid_d, resp_err_d, fpu_dval_d, busy_d;
    logic [31:0]        resp_result_d, fpu_din1_d, fpu_din2_d;
    logic [TAG_W-1:0]   resp_tag_d;
    logic [3:0]         fpu_cmd_d;

`ifdef FPU_SEQ_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);
    localparam logic [31:0] QNAN  = 32'h7FC0_0000;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
`endif

    assign push      = req_valid & req_ready;
    assign head      = mem[rd_ptr_q];
    assign head_cmd  = head[ENT_W-1 -: 4];
    assign head_din1 = head[TAG_W+63 -: 32];
    assign head_din2 = head[TAG_W+31 -: 32];
    assign head_tag  = head[TAG_W-1:0];

    always_comb begin
        case (head_cmd)
            CMD_FPU_SP_ADD, CMD_FPU_SP_MUL, CMD_FPU_SP_DIV,
            CMD_FPU_SP_F2I, CMD_FPU_SP_I2F: head_ok = 1'b1;
            default:                        head_ok = 1'b0;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        pop           = 1'b0;
        fpu_dval_d    = 1'b0;
        fpu_cmd_d     = fpu_cmd;
        fpu_din1_d    = fpu_din1;
        fpu_din2_d    = fpu_din2;
        resp_valid_d  = resp_valid;
        resp_result_d = resp_result;
        resp_tag_d    = resp_tag;
        resp_err_d    = resp_err;
`ifdef FPU_SEQ_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (level != '0) begin
                    pop        = 1'b1;
                    resp_tag_d = head_tag;
                    if (head_ok) begin
                        fpu_cmd_d  = head_cmd;
                        fpu_din1_d = head_din1;
                        fpu_din2_d = head_din2;
                        fpu_dval_d = 1'b1;
                        state_d    = ST_ISSUE;
                    end else begin
                        resp_result_d = '0;
                        resp_err_d    = 1'b1;
                        resp_valid_d  = 1'b1;
                        state_d       = ST_RESP;
                    end
                end
            end
            ST_ISSUE: begin
`ifdef FPU_SEQ_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (fpu_rdy) begin
                    resp_result_d = fpu_result;
                    resp_err_d    = 1'b0;
                    resp_valid_d  = 1'b1;
                    state_d       = ST_RESP;
                end
`ifdef FPU_SEQ_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_W'(TMO_CYC - 1)) begin
                    resp_result_d = QNAN;
                    resp_err_d    = 1'b1;
                    resp_valid_d  = 1'b1;
                    fpu_cmd_d     = IDLE_CMD;
                    state_d       = ST_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
`endif
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    fpu_cmd_d    = IDLE_CMD;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case ({push, pop})
            2'b10:   level_d = level + LVL_W'(1);
            2'b01:   level_d = level - LVL_W'(1);
            default: level_d = level;
        endcase
        req_ready_d = (level_d != LVL_W'(DEPTH));
        busy_d      = (level_d != '0) || (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {req_cmd, req_din1, req_din2, req_tag};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level       <= '0;
            req_ready   <= 1'b1;
            busy        <= 1'b0;
            resp_valid  <= 1'b0;
            resp_result <= '0;
            resp_tag    <= '0;
            resp_err    <= 1'b0;
            fpu_cmd     <= IDLE_CMD;
            fpu_din1    <= '0;
            fpu_din2    <= '0;
            fpu_dval    <= 1'b0;
`ifdef FPU_SEQ_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level       <= level_d;
            req_ready   <= req_ready_d;
            busy        <= busy_d;
            resp_valid  <= resp_valid_d;
            resp_result <= resp_result_d;
            resp_tag    <= resp_tag_d;
            resp_err    <= resp_err_d;
            fpu_cmd     <= fpu_cmd_d;
            fpu_din1    <= fpu_din1_d;
            fpu_din2    <= fpu_din2_d;
            fpu_dval    <= fpu_dval_d;
`ifdef FPU_SEQ_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_fpu_sp_cmd_seq.sv
// Scoreboard bench for fpu_sp_cmd_seq with a behavioural FPU of programmable latency.
module tb_fpu_sp_cmd_seq;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TMO_CYC = 64;
    localparam logic [3:0] ADD  = 4'h0;
    localparam logic [3:0] MUL  = 4'h1;
    localparam logic [3:0] DIV  = 4'h2;
    localparam logic [3:0] IDLE = 4'hF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready;
    logic [3:0]  req_cmd = '0;
    logic [31:0] req_din1 = '0, req_din2 = '0;
    logic [3:0]  req_tag = '0;
    logic        resp_valid, resp_ready = 1'b0;
    logic [31:0] resp_result;
    logic [3:0]  resp_tag;
    logic        resp_err;
    logic [3:0]  fpu_cmd;
    logic [31:0] fpu_din1, fpu_din2;
    logic        fpu_dval;
    logic [31:0] fpu_result = '0;
    logic        fpu_rdy = 1'b0;
    logic        busy;
    logic [2:0]  level;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct packed {logic [3:0] tag; logic err; logic [31:0] res;} exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    fpu_sp_cmd_seq #(.DEPTH(DEPTH), .TAG_W(4), .IDLE_CMD(IDLE), .TMO_CYC(TMO_CYC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_din1(req_din1), .req_din2(req_din2), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .resp_tag(resp_tag), .resp_err(resp_err),
        .fpu_cmd(fpu_cmd), .fpu_din1(fpu_din1), .fpu_din2(fpu_din2), .fpu_dval(fpu_dval),
        .fpu_result(fpu_result), .fpu_rdy(fpu_rdy),
        .busy(busy), .level(level)
    );

    // Behavioural FPU: known test-plan results, otherwise a reversible stand-in
    function automatic logic [31:0] fpu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        if (c == ADD && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (c == MUL && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
        if (c == DIV && a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
        return a ^ b ^ {28'd0, c};
    endfunction

    int          fpu_lat  = 2;
    bit          fpu_hang = 1'b0;
    int          cyc = 0, dval_cnt = 0, last_dval = 0, min_gap = 1000, cnt = 0;
    bit          pend = 1'b0, stable_bad = 1'b0, dval_wide = 1'b0, prev_dval = 1'b0;
    logic [3:0]  c_cmd = '0;
    logic [31:0] c_d1 = '0, c_d2 = '0;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        fpu_rdy   <= 1'b0;
        prev_dval <= fpu_dval;
        if (fpu_dval && prev_dval) dval_wide <= 1'b1;
        if (rst) begin
            pend <= 1'b0;
        end else if (fpu_dval) begin
            pend      <= 1'b1;
            cnt       <= fpu_lat - 1;
            c_cmd     <= fpu_cmd;
            c_d1      <= fpu_din1;
            c_d2      <= fpu_din2;
            dval_cnt  <= dval_cnt + 1;
            last_dval <= cyc;
            if (dval_cnt > 0 && cyc - last_dval < min_gap) min_gap <= cyc - last_dval;
        end else if (pend && !fpu_hang) begin
            if (fpu_cmd !== c_cmd || fpu_din1 !== c_d1 || fpu_din2 !== c_d2) stable_bad <= 1'b1;
            if (cnt == 0) begin
                fpu_rdy    <= 1'b1;
                fpu_result <= fpu_fn(c_cmd, c_d1, c_d2);
                pend       <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    task automatic send_req(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] t);
        int   n = 0;
        logic acc = 1'b0;
        req_valid = 1'b1; req_cmd = c; req_din1 = a; req_din2 = b; req_tag = t;
        while (!acc && n < 200) begin
            acc = req_ready;
            @(posedge clk); #1;
            n++;
        end
        req_valid = 1'b0;
        n_cmp++;
        if (!acc) begin
            n_fail++;
            $display("FAIL send_req tag %0d: req_ready stayed 0 for %0d cycles, required 1", t, n);
        end
    endtask

    task automatic wait_resp(output bit ok, output logic [31:0] r, output logic [3:0] t, output logic e);
        int n = 0;
        ok = 1'b0; r = '0; t = '0; e = 1'b0;
        while (resp_valid !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (resp_valid === 1'b1) begin
            ok = 1'b1; r = resp_result; t = resp_tag; e = resp_err;
            resp_ready = 1'b1;
            @(posedge clk); #1;
            resp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({req_ready, resp_valid, resp_err, fpu_dval, busy} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 10000", {req_ready, resp_valid, resp_err, fpu_dval, busy});
        end
        n_cmp++;
        if (fpu_cmd !== IDLE) begin n_fail++; $display("FAIL reset_fpu_cmd: got %h, required %h", fpu_cmd, IDLE); end
        n_cmp++;
        if ({fpu_din1, fpu_din2} !== 64'd0) begin
            n_fail++; $display("FAIL reset_fpu_din: got %h %h, required 0", fpu_din1, fpu_din2);
        end
        n_cmp++;
        if ({resp_result, resp_tag} !== 36'd0) begin
            n_fail++; $display("FAIL reset_resp: got %h tag %h, required 0", resp_result, resp_tag);
        end
        n_cmp++;
        if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d, required 0", level); end
    endtask

    task automatic test_add();
        bit ok; logic [31:0] r; logic [3:0] t; logic e; exp_t x;
        int d0 = dval_cnt;
        int n = 0;
        fpu_lat = 2;
        exp_q.push_back({4'd3, 1'b0, 32'h40400000});
        send_req(ADD, 32'h3F800000, 32'h40000000, 4'd3);
        while (resp_valid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        n_cmp++;
        if (n != 3 + fpu_lat) begin n_fail++; $display("FAIL add_latency: got %0d cycles, required %0d", n, 3 + fpu_lat); end
        wait_resp(ok, r, t, e);
        x = exp_q.pop_front();
        n_cmp++;
        if (!ok || {t, e, r} !== {x.tag, x.err, x.res}) begin
            n_fail++; $display("FAIL add_resp: got tag %0d err %b res %h, required tag %0d err %b res %h", t, e, r, x.tag, x.err, x.res);
        end
        n_cmp++;
        if (dval_cnt - d0 != 1) begin n_fail++; $display("FAIL add_dval_count: got %0d, required 1", dval_cnt - d0); end
    endtask

    task automatic test_back_to_back();
        bit ok; logic [31:0] r; logic [3:0] t; logic e; exp_t x;
        int d0 = dval_cnt;
        fpu_lat = 1;
        exp_q.push_back({4'd1, 1'b0, 32'h40C00000});
        exp_q.push_back({4'd2, 1'b0, 32'h40400000});
        send_req(MUL, 32'h40000000, 32'h40400000, 4'd1);
        send_req(DIV, 32'h40C00000, 32'h40000000, 4'd2);
        for (int i = 0; i < 2; i++) begin
            wait_resp(ok, r, t, e);
            x = exp_q.pop_front();
            n_cmp++;
            if (!ok || {t, e, r} !== {x.tag, x.err, x.res}) begin
                n_fail++; $display("FAIL b2b_resp%0d: got tag %0d err %b res %h, required tag %0d err %b res %h", i, t, e, r, x.tag, x.err, x.res);
            end
        end
        n_cmp++;
        if (min_gap < 4 || dval_wide) begin n_fail++; $display("FAIL b2b_dval_spacing: got gap %0d wide %b, required >=4 and 0", min_gap, dval_wide); end
        n_cmp++;
        if (dval_cnt - d0 != 2) begin n_fail++; $display("FAIL b2b_dval_count: got %0d, required 2", dval_cnt - d0); end
        n_cmp++;
        if (stable_bad) begin n_fail++; $display("FAIL fpu_inputs_stable: got changed, required stable until rdy"); end
    endtask

    task automatic test_fill();
        bit ok; logic [31:0] r; logic [3:0] t; logic e; exp_t x;
        logic [31:0] a, b;
        logic [3:0]  c;
        fpu_lat = 3;
        for (int i = 0; i <= DEPTH; i++) begin
            a = $urandom; b = $urandom; c = 4'(i % 5);
            exp_q.push_back({4'(8 + i), 1'b0, a ^ b ^ {28'd0, c}});
            send_req(c, a, b, 4'(8 + i));
        end
        repeat (8) @(posedge clk);
        #1;
        n_cmp++;
        if (level !== 3'(DEPTH) || req_ready !== 1'b0) begin
            n_fail++; $display("FAIL fill_full: got level %0d ready %b, required %0d and 0", level, req_ready, DEPTH);
        end
        a = 32'h12345678; b = 32'h0F0F0F0F;
        exp_q.push_back({4'd14, 1'b0, a ^ b ^ {28'd0, MUL}});
        fork
            send_req(MUL, a, b, 4'd14);
            begin
                repeat (5) @(posedge clk);
                #1;
                n_cmp++;
                if (level !== 3'(DEPTH) || req_ready !== 1'b0) begin
                    n_fail++; $display("FAIL fill_stall: got level %0d ready %b, required %0d and 0", level, req_ready, DEPTH);
                end
                for (int i = 0; i < DEPTH + 2; i++) begin
                    wait_resp(ok, r, t, e);
                    x = exp_q.pop_front();
                    n_cmp++;
                    if (!ok || {t, e, r} !== {x.tag, x.err, x.res}) begin
                        n_fail++; $display("FAIL fill_drain%0d: got tag %0d err %b res %h, required tag %0d err %b res %h", i, t, e, r, x.tag, x.err, x.res);
                    end
                end
            end
        join
    endtask

    task automatic test_unsupported();
        bit ok; logic [31:0] r; logic [3:0] t; logic e; exp_t x;
        int d0 = dval_cnt;
        exp_q.push_back({4'd5, 1'b1, 32'h0});
        send_req(IDLE, 32'hDEADBEEF, 32'h1, 4'd5);
        wait_resp(ok, r, t, e);
        x = exp_q.pop_front();
        n_cmp++;
        if (!ok || {t, e, r} !== {x.tag, x.err, x.res}) begin
            n_fail++; $display("FAIL unsup_resp: got tag %0d err %b res %h, required tag %0d err %b res %h", t, e, r, x.tag, x.err, x.res);
        end
        n_cmp++;
        if (dval_cnt != d0) begin n_fail++; $display("FAIL unsup_dval: got %0d pulses, required 0", dval_cnt - d0); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        fpu_lat = 50;
        for (int i = 0; i < 3; i++) send_req(ADD, 32'(i), 32'(i + 1), 4'(i));
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (level !== 3'd2 || pend !== 1'b1) begin
            n_fail++; $display("FAIL rst_setup: got level %0d pend %b, required 2 and 1", level, pend);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if (level !== 3'd0 || resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_flush: got level %0d valid %b busy %b ready %b, required 0 0 0 1", level, resp_valid, busy, req_ready);
        end
        n_cmp++;
        if (fpu_cmd !== IDLE || fpu_dval !== 1'b0) begin
            n_fail++; $display("FAIL rst_fpu_cmd: got %h dval %b, required %h 0", fpu_cmd, fpu_dval, IDLE);
        end
        resp_ready = 1'b1;
        repeat (60) begin @(posedge clk); #1; if (resp_valid === 1'b1) seen++; end
        resp_ready = 1'b0;
        n_cmp++;
        if (seen != 0) begin n_fail++; $display("FAIL rst_no_resp: got %0d valid cycles, required 0", seen); end
        fpu_lat = 2;
    endtask

`ifdef FPU_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        bit ok; logic [31:0] r; logic [3:0] t; logic e;
        int n = 0;
        fpu_hang = 1'b1;
        send_req(ADD, 32'h1, 32'h2, 4'd9);
        while (resp_valid !== 1'b1 && n < 300) begin @(posedge clk); #1; n++; end
        n_cmp++;
        if (n != 2 + TMO_CYC) begin n_fail++; $display("FAIL tmo_cycles: got %0d, required %0d", n, 2 + TMO_CYC); end
        n_cmp++;
        if (fpu_cmd !== IDLE) begin n_fail++; $display("FAIL tmo_fpu_cmd: got %h, required %h", fpu_cmd, IDLE); end
        wait_resp(ok, r, t, e);
        n_cmp++;
        if (!ok || {t, e, r} !== {4'd9, 1'b1, 32'h7FC00000}) begin
            n_fail++; $display("FAIL tmo_resp: got tag %0d err %b res %h, required tag 9 err 1 res 7fc00000", t, e, r);
        end
        fpu_hang = 1'b0;
    endtask
`endif

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_add();
        test_back_to_back();
        test_fill();
        test_unsupported();
        test_reset_mid();
`ifdef FPU_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
